// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared state encoding for the sequential multiplier
package mul_pkg;
    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/adder.sv
// rtl/adder.sv - SIZE-bit ripple adder with carry in/out
module adder #(
    parameter int SIZE = 32
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            carryIn,
    output logic [SIZE-1:0] sum,
    output logic            carryOut
);
    assign {carryOut, sum} = {1'b0, a} + {1'b0, b} + {{SIZE{1'b0}}, carryIn};
endmodule

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - shift-and-add multiplier, one partial product per cycle; SEQ_MUL_SIGNED_EN adds signed operands
module seq_multiplier
    import mul_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [SIZE-1:0]   multiplicand,
    input  logic [SIZE-1:0]   multiplier,
`ifdef SEQ_MUL_SIGNED_EN
    input  logic              signed_op,
`endif
    output logic              busy,
    output logic              done,
    output logic [2*SIZE-1:0] product
);
    localparam int CW = $clog2(SIZE);

    state_t          state;
    logic [SIZE-1:0] mcand;
    logic [SIZE-1:0] acc;
    logic [SIZE-1:0] mq;
    logic [CW-1:0]   count;
    logic [SIZE-1:0] sum;
    logic            carry;
    logic [SIZE-1:0] load_a;
    logic [SIZE-1:0] load_b;

    adder #(.SIZE(SIZE)) u_adder (
        .a        (acc),
        .b        (mq[0] ? mcand : {SIZE{1'b0}}),
        .carryIn  (1'b0),
        .sum      (sum),
        .carryOut (carry)
    );

`ifdef SEQ_MUL_SIGNED_EN
    logic              neg;
    logic              load_neg;
    logic [2*SIZE-1:0] negated;

    // Magnitudes as unsigned values: the most negative input maps to 2^(SIZE-1)
    assign load_a   = (signed_op && multiplicand[SIZE-1]) ? (~multiplicand + 1'b1) : multiplicand;
    assign load_b   = (signed_op && multiplier[SIZE-1])   ? (~multiplier + 1'b1)   : multiplier;
    assign load_neg = signed_op & (multiplicand[SIZE-1] ^ multiplier[SIZE-1]);
    assign negated  = ~{acc, mq} + {{(2*SIZE-1){1'b0}}, 1'b1};
`else
    assign load_a = multiplicand;
    assign load_b = multiplier;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            mcand   <= '0;
            acc     <= '0;
            mq      <= '0;
            count   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
`ifdef SEQ_MUL_SIGNED_EN
            neg     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // busy also covers the done cycle, which is spent back in IDLE
                    busy <= start;
                    if (start) begin
                        mcand <= load_a;
                        acc   <= '0;
                        mq    <= load_b;
                        count <= CW'(SIZE - 1);
`ifdef SEQ_MUL_SIGNED_EN
                        neg   <= load_neg;
`endif
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc   <= {carry, sum[SIZE-1:1]};
                    mq    <= {sum[0], mq[SIZE-1:1]};
                    count <= count - 1'b1;
                    if (count == '0) begin
`ifdef SEQ_MUL_SIGNED_EN
                        state <= FIXUP;
`else
                        state <= DONE;
`endif
                    end
                end
`ifdef SEQ_MUL_SIGNED_EN
                FIXUP: begin
                    if (neg) begin
                        acc <= negated[2*SIZE-1:SIZE];
                        mq  <= negated[SIZE-1:0];
                    end
                    state <= DONE;
                end
`endif
                DONE: begin
                    product <= {acc, mq};
                    done    <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - randomized self-checking bench for seq_multiplier at SIZE=4
module tb_seq_multiplier;
    localparam int SIZE = 4;
`ifdef SEQ_MUL_SIGNED_EN
    localparam int LAT = SIZE + 2;
`else
    localparam int LAT = SIZE + 1;
`endif
    localparam int PER = LAT + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [SIZE-1:0]   multiplicand;
    logic [SIZE-1:0]   multiplier;
`ifdef SEQ_MUL_SIGNED_EN
    logic              signed_op;
`endif
    logic              busy;
    logic              done;
    logic [2*SIZE-1:0] product;

    int vectors = 0;
    int miscompares = 0;

    seq_multiplier #(.SIZE(SIZE)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
`ifdef SEQ_MUL_SIGNED_EN
        .signed_op    (signed_op),
`endif
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer product, truncated to 2*SIZE bits
    function automatic int model(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b, input logic s);
        int ia;
        int ib;
        int p;
        ia = s ? int'($signed(a)) : int'(a);
        ib = s ? int'($signed(b)) : int'(b);
        p  = ia * ib;
        return p & ((1 << (2 * SIZE)) - 1);
    endfunction

    function automatic logic rand_sign();
`ifdef SEQ_MUL_SIGNED_EN
        return 1'($urandom_range(0, 1));
`else
        return 1'b0;
`endif
    endfunction

    task automatic drive_ops(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b, input logic s);
        multiplicand = a;
        multiplier   = b;
`ifdef SEQ_MUL_SIGNED_EN
        signed_op    = s;
`else
        if (s) $display("note: signed request ignored in unsigned build");
`endif
    endtask

    task automatic do_mul(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b, input logic s, input string tag);
        int   lat;
        logic busy_ok;
        int   exp;
        exp = model(a, b, s);
        @(negedge clk);
        drive_ops(a, b, s);
        start = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        busy_ok = busy;
        lat     = 0;
        while (lat <= 4 * LAT) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
            if (!busy) busy_ok = 1'b0;
        end
        check({tag, " latency"}, lat, LAT);
        check({tag, " product"}, int'(product), exp);
        check({tag, " busy"}, int'(busy_ok & busy), 1);
        @(posedge clk);
        #1;
        check({tag, " done width"}, int'(done), 0);
        check({tag, " busy end"}, int'(busy), 0);
        check({tag, " product hold"}, int'(product), exp);
    endtask

    logic [SIZE-1:0] oa [0:63];
    logic [SIZE-1:0] ob [0:63];
    logic            os [0:63];

    initial begin
        reset = 1'b1;
        start = 1'b0;
        drive_ops('0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset product", int'(product), 0);
        @(negedge clk);
        reset = 1'b0;

        do_mul(4'd3, 4'd5, 1'b0, "3x5");
        do_mul(4'd15, 4'd15, 1'b0, "15x15");
        do_mul(4'd0, 4'd9, 1'b0, "0x9");
        do_mul(4'd12, 4'd10, 1'b0, "12x10");

`ifdef SEQ_MUL_SIGNED_EN
        do_mul(4'hD, 4'h5, 1'b1, "s -3x5");
        do_mul(4'h8, 4'h8, 1'b1, "s -8x-8");
        do_mul(4'h8, 4'h7, 1'b1, "s -8x7");
        do_mul(4'hD, 4'h5, 1'b0, "u Dx5");
`endif

        for (int i = 0; i < 20; i++) begin
            do_mul(4'($urandom), 4'($urandom), rand_sign(), "random");
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        // start held high: only operands present at accepting edges matter
        @(negedge clk);
        for (int n = 0; n <= 3 * PER + LAT; n++) begin
            oa[n] = 4'($urandom);
            ob[n] = 4'($urandom);
            os[n] = rand_sign();
            drive_ops(oa[n], ob[n], os[n]);
            start = 1'b1;
            @(posedge clk);
            #1;
            if (n >= LAT && (n - LAT) % PER == 0) begin
                check("b2b done", int'(done), 1);
                check("b2b product", int'(product), model(oa[n-LAT], ob[n-LAT], os[n-LAT]));
            end else begin
                check("b2b quiet", int'(done), 0);
            end
            @(negedge clk);
        end
        start = 1'b0;
        repeat (3) @(posedge clk);

        // reset two cycles into an operation discards it
        @(negedge clk);
        drive_ops(4'd7, 4'd7, 1'b0);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midreset busy", int'(busy), 0);
        check("midreset done", int'(done), 0);
        check("midreset product", int'(product), 0);
        @(negedge clk);
        reset = 1'b0;
        begin
            logic saw_done;
            saw_done = 1'b0;
            repeat (2 * PER) begin
                @(posedge clk);
                #1;
                if (done) saw_done = 1'b1;
            end
            check("midreset no done", int'(saw_done), 0);
        end
        do_mul(4'd2, 4'd3, 1'b0, "2x3");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
